// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin two-port arbiter in front of a single-port async-read memory; MEM_ARB_STATS_EN adds per-port wait counters
module mem_port_arbiter #(
  parameter int WIDTH     = 16,
  parameter int DEPTH     = 1024,
  parameter int ADD_SIZE  = $clog2(DEPTH),
  parameter int MAX_BURST = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                a_req,
  input  logic                b_req,
  input  logic                a_lock,
  input  logic                b_lock,
  input  logic                a_we,
  input  logic                b_we,
  input  logic [ADD_SIZE-1:0] a_addr,
  input  logic [ADD_SIZE-1:0] b_addr,
  input  logic [WIDTH-1:0]    a_wdata,
  input  logic [WIDTH-1:0]    b_wdata,
  output logic                a_ack,
  output logic                b_ack,
  output logic [WIDTH-1:0]    a_rdata,
  output logic [WIDTH-1:0]    b_rdata,
  output logic                a_rvalid,
  output logic                b_rvalid,
  output logic [ADD_SIZE-1:0] mem_addr,
  output logic                mem_we,
  output logic [WIDTH-1:0]    mem_wdata,
  input  logic [WIDTH-1:0]    mem_rdata,
  output logic [1:0]          owner
`ifdef MEM_ARB_STATS_EN
  ,
  input  logic                stats_clr,
  output logic [15:0]         a_wait_cnt,
  output logic [15:0]         b_wait_cnt
`endif
);
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam logic [BW-1:0] LAST = BW'(MAX_BURST - 1);
  typedef enum logic [1:0] {IDLE = 2'b00, GNT_A = 2'b01, GNT_B = 2'b10} state_t;
  state_t          state_q, state_d;
  logic            rr_q, rr_d;
  logic [BW-1:0]   cnt_q, cnt_d;
  logic            pick_a;
  logic [WIDTH-1:0] a_rdata_q, b_rdata_q;
  logic            a_rvalid_q, b_rvalid_q;
  // next grant: round-robin from IDLE, burst length capped only while the other port waits
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    cnt_d   = (cnt_q == LAST) ? cnt_q : cnt_q + 1'b1;
    pick_a  = a_req & (!b_req | !rr_q);
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (a_req | b_req) begin
          state_d = pick_a ? GNT_A : GNT_B;
          rr_d    = pick_a;
        end
      end
      GNT_A: if (!(a_lock & (!b_req | cnt_q != LAST))) begin
        state_d = b_req ? GNT_B : IDLE;
        cnt_d   = '0;
      end
      GNT_B: if (!(b_lock & (!a_req | cnt_q != LAST))) begin
        state_d = a_req ? GNT_A : IDLE;
        cnt_d   = '0;
      end
      default: state_d = IDLE;
    endcase
  end
  // memory mux driven by the current owner; zero when idle so the bus is quiet
  always_comb begin
    a_ack     = (state_q == GNT_A) & a_req;
    b_ack     = (state_q == GNT_B) & b_req;
    mem_we    = (a_ack & a_we) | (b_ack & b_we);
    mem_addr  = (state_q == GNT_A) ? a_addr : (state_q == GNT_B) ? b_addr : '0;
    mem_wdata = (state_q == GNT_A) ? a_wdata : (state_q == GNT_B) ? b_wdata : '0;
    owner     = state_q;
  end
  // grant state and registered read return
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      rr_q       <= 1'b0;
      cnt_q      <= '0;
      a_rdata_q  <= '0;
      b_rdata_q  <= '0;
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_q       <= rr_d;
      cnt_q      <= cnt_d;
      a_rvalid_q <= a_ack & !a_we;
      b_rvalid_q <= b_ack & !b_we;
      if (a_ack & !a_we) a_rdata_q <= mem_rdata;
      if (b_ack & !b_we) b_rdata_q <= mem_rdata;
    end
  end
  assign a_rdata  = a_rdata_q;
  assign b_rdata  = b_rdata_q;
  assign a_rvalid = a_rvalid_q;
  assign b_rvalid = b_rvalid_q;
`ifdef MEM_ARB_STATS_EN
  logic [15:0] a_wait_q, b_wait_q;
  // saturating count of cycles each port spent requesting without being served
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_wait_q <= '0;
      b_wait_q <= '0;
    end else if (stats_clr) begin
      a_wait_q <= '0;
      b_wait_q <= '0;
    end else begin
      if (a_req & !a_ack & (a_wait_q != 16'hFFFF)) a_wait_q <= a_wait_q + 16'd1;
      if (b_req & !b_ack & (b_wait_q != 16'hFFFF)) b_wait_q <= b_wait_q + 16'd1;
    end
  end
  assign a_wait_cnt = a_wait_q;
  assign b_wait_cnt = b_wait_q;
`endif
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard bench for mem_port_arbiter with requester drivers and a memory model
module tb_mem_port_arbiter;
  localparam int MB = 4;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  logic a_req, b_req, a_lock, b_lock, a_we, b_we;
  logic [9:0] a_addr, b_addr, mem_addr;
  logic [15:0] a_wdata, b_wdata, a_rdata, b_rdata, mem_wdata, mem_rdata;
  logic a_ack, b_ack, a_rvalid, b_rvalid, mem_we;
  logic [1:0] owner;
`ifdef MEM_ARB_STATS_EN
  logic stats_clr = 0;
  logic [15:0] a_wait_cnt, b_wait_cnt;
`endif
  mem_port_arbiter #(.WIDTH(16), .DEPTH(1024), .MAX_BURST(MB)) dut (
    .clk(clk), .rst(rst), .a_req(a_req), .b_req(b_req), .a_lock(a_lock), .b_lock(b_lock),
    .a_we(a_we), .b_we(b_we), .a_addr(a_addr), .b_addr(b_addr), .a_wdata(a_wdata), .b_wdata(b_wdata),
    .a_ack(a_ack), .b_ack(b_ack), .a_rdata(a_rdata), .b_rdata(b_rdata), .a_rvalid(a_rvalid), .b_rvalid(b_rvalid),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .owner(owner)
`ifdef MEM_ARB_STATS_EN
    , .stats_clr(stats_clr), .a_wait_cnt(a_wait_cnt), .b_wait_cnt(b_wait_cnt)
`endif
  );
  logic [15:0] mem [1024];
  logic [15:0] shadow [1024];
  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;
  typedef struct packed {logic we; logic lock; logic [9:0] addr; logic [15:0] data;} txn_t;
  txn_t a_q[$], b_q[$], a_exp[$], b_exp[$];
  logic [15:0] a_rq[$], b_rq[$];
  int a_log[$], b_log[$], a_rvlog[$], b_rvlog[$];
  int cyc = 0, tests = 0, fails = 0, a_start = 0, b_start = 0, a_wt = 0, b_wt = 0;
  bit chk_en = 0;
  logic a_ack_s = 0, b_ack_s = 0;
  logic [15:0] b_last = 0;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask
  function automatic int nth(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction
  task automatic iss(input bit p, input logic we, input logic lock, input logic [9:0] addr, input logic [15:0] d);
    txn_t t;
    t = {we, lock, addr, d};
    if (p) begin b_q.push_back(t); b_exp.push_back(t); end
    else begin a_q.push_back(t); a_exp.push_back(t); end
  endtask
  task automatic clr_logs();
    a_log.delete(); b_log.delete(); a_rvlog.delete(); b_rvlog.delete();
  endtask
  task automatic drain(input string n);
    int k = 0;
    while (!(a_q.size() == 0 && b_q.size() == 0 && a_rq.size() == 0 && b_rq.size() == 0 && owner == 2'b00) && k < 2000) begin
      @(negedge clk); #2; k++;
    end
    chk({n, "_drain_timeout"}, k < 2000, 1);
    @(negedge clk); #2;
  endtask
  task automatic rst_chk(input string n);
    chk({n, "_owner"}, owner, 0);
    chk({n, "_a_ack"}, a_ack, 0);
    chk({n, "_b_ack"}, b_ack, 0);
    chk({n, "_mem_we"}, mem_we, 0);
    chk({n, "_mem_addr"}, mem_addr, 0);
    chk({n, "_mem_wdata"}, mem_wdata, 0);
    chk({n, "_a_rvalid"}, a_rvalid, 0);
    chk({n, "_b_rvalid"}, b_rvalid, 0);
    chk({n, "_a_rdata"}, a_rdata, 0);
    chk({n, "_b_rdata"}, b_rdata, 0);
  endtask
  initial begin
    a_req = 0; a_lock = 0; a_we = 0; a_addr = 0; a_wdata = 0;
    forever begin
      @(posedge clk); #1;
      if (a_req && a_ack_s) void'(a_q.pop_front());
      if (!a_req && a_q.size() > 0) a_start = cyc;
      a_req = a_q.size() > 0;
      if (a_req) {a_we, a_lock, a_addr, a_wdata} = a_q[0];
      else begin a_we = 0; a_lock = 0; a_addr = 0; a_wdata = 0; end
    end
  end
  initial begin
    b_req = 0; b_lock = 0; b_we = 0; b_addr = 0; b_wdata = 0;
    forever begin
      @(posedge clk); #1;
      if (b_req && b_ack_s) void'(b_q.pop_front());
      if (!b_req && b_q.size() > 0) b_start = cyc;
      b_req = b_q.size() > 0;
      if (b_req) {b_we, b_lock, b_addr, b_wdata} = b_q[0];
      else begin b_we = 0; b_lock = 0; b_addr = 0; b_wdata = 0; end
    end
  end
  initial begin
    txn_t t;
    logic [15:0] e;
    forever begin
      @(negedge clk);
      a_ack_s = a_ack;
      b_ack_s = b_ack;
      if (chk_en) begin
        chk("ack_exclusive", a_ack & b_ack, 0);
        chk("we_without_ack", mem_we & !a_ack & !b_ack, 0);
        chk("owner_match", (a_ack && owner != 2'b01) || (b_ack && owner != 2'b10), 0);
        if (a_rvalid) begin
          a_rvlog.push_back(cyc);
          if (a_rq.size() == 0) chk("a_rvalid_unexpected", 1, 0);
          else begin e = a_rq.pop_front(); chk("a_rdata", a_rdata, e); end
        end
        if (b_rvalid) begin
          b_rvlog.push_back(cyc);
          b_last = b_rdata;
          if (b_rq.size() == 0) chk("b_rvalid_unexpected", 1, 0);
          else begin e = b_rq.pop_front(); chk("b_rdata", b_rdata, e); end
        end
        if (a_ack) begin
          a_log.push_back(cyc);
          chk("a_wait_bound", a_wt <= MB + 1, 1);
          a_wt = 0;
          if (a_exp.size() == 0) chk("a_ack_unexpected", 1, 0);
          else begin
            t = a_exp.pop_front();
            chk("a_mem_addr", mem_addr, t.addr);
            chk("a_mem_we", mem_we, t.we);
            if (t.we) begin chk("a_mem_wdata", mem_wdata, t.data); shadow[t.addr] = t.data; end
            else a_rq.push_back(shadow[t.addr]);
          end
        end else if (a_req) a_wt++;
        if (b_ack) begin
          b_log.push_back(cyc);
          chk("b_wait_bound", b_wt <= MB + 1, 1);
          b_wt = 0;
          if (b_exp.size() == 0) chk("b_ack_unexpected", 1, 0);
          else begin
            t = b_exp.pop_front();
            chk("b_mem_addr", mem_addr, t.addr);
            chk("b_mem_we", mem_we, t.we);
            if (t.we) begin chk("b_mem_wdata", mem_wdata, t.data); shadow[t.addr] = t.data; end
            else b_rq.push_back(shadow[t.addr]);
          end
        end else if (b_req) b_wt++;
      end
    end
  end
  initial begin
    int k;
    bit seen;
    for (int i = 0; i < 1024; i++) begin mem[i] = 0; shadow[i] = 0; end
    #2 rst = 0;
    #1 rst_chk("reset");
    repeat (2) @(negedge clk);
    rst = 1;
    chk_en = 1;
    #2;
    clr_logs(); iss(0, 0, 0, 10'h000, 0); iss(1, 0, 0, 10'h001, 0); drain("pair1");
    chk("pair1_a_first", nth(a_log, 0), a_start + 1);
    chk("pair1_b_second", nth(b_log, 0), a_start + 2);
    clr_logs(); iss(0, 0, 0, 10'h002, 0); iss(1, 0, 0, 10'h003, 0); drain("pair2");
    chk("pair2_b_first", nth(b_log, 0), b_start + 1);
    chk("pair2_a_second", nth(a_log, 0), b_start + 2);
    clr_logs(); iss(0, 1, 0, 10'h010, 16'hBEEF); drain("a_write");
    chk("a_write_ack_cycle", nth(a_log, 0), a_start + 1);
    clr_logs(); iss(1, 0, 0, 10'h010, 0); drain("b_read");
    chk("b_read_ack_cycle", nth(b_log, 0), b_start + 1);
    chk("b_read_rvalid_cycle", nth(b_rvlog, 0), b_start + 2);
    chk("b_read_data", b_last, 16'hBEEF);
    clr_logs();
    for (int i = 0; i < 8; i++) iss(0, 1, 1, 10'(32'h100 + i), 16'(32'h1000 + i));
    iss(1, 0, 0, 10'h010, 0);
    drain("burst");
    for (int i = 0; i < 8; i++) chk($sformatf("burst_a_ack%0d", i), nth(a_log, i), a_start + 1 + i + (i >= 4 ? 1 : 0));
    chk("burst_b_ack", nth(b_log, 0), a_start + 5);
    chk("burst_b_count", b_log.size(), 1);
    clr_logs(); iss(0, 0, 0, 10'h000, 0); iss(0, 0, 0, 10'h001, 0); drain("bubble");
    chk("bubble_ack0", nth(a_log, 0), a_start + 1);
    chk("bubble_ack1", nth(a_log, 1), a_start + 3);
    chk("bubble_rvalid0", nth(a_rvlog, 0), a_start + 2);
    chk("bubble_rvalid1", nth(a_rvlog, 1), a_start + 4);
`ifdef MEM_ARB_STATS_EN
    stats_clr = 1; @(negedge clk); stats_clr = 0; #2;
    chk("stats_pre_clr_a", a_wait_cnt, 0);
    iss(0, 1, 1, 10'h200, 16'h0001); iss(0, 1, 1, 10'h201, 16'h0002); iss(0, 1, 0, 10'h202, 16'h0003);
    k = 0;
    while (!a_req && k < 10) begin @(negedge clk); #2; k++; end
    chk("stats_a_start_timeout", k < 10, 1);
    iss(1, 0, 0, 10'h200, 0);
    drain("stats");
    chk("stats_b_wait", b_wait_cnt, 3);
    chk("stats_a_wait", a_wait_cnt, 1);
    stats_clr = 1; @(negedge clk); stats_clr = 0; #2;
    chk("stats_clr_a", a_wait_cnt, 0);
    chk("stats_clr_b", b_wait_cnt, 0);
`endif
    repeat (400) begin
      @(negedge clk); #2;
      if (a_q.size() < 3 && $urandom_range(0, 2) == 0)
        iss(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 10'($urandom_range(0, 15)), 16'($urandom));
      if (b_q.size() < 3 && $urandom_range(0, 2) == 0)
        iss(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 10'($urandom_range(0, 15)), 16'($urandom));
    end
    drain("random");
    for (int i = 0; i < 4; i++) begin iss(0, 1, 1, 10'(32'h300 + i), 16'h5A5A); iss(1, 1, 1, 10'(32'h310 + i), 16'hA5A5); end
    seen = 0;
    for (int i = 0; i < 50 && !seen; i++) begin @(negedge clk); seen = mem_we; end
    chk("midrst_traffic_seen", seen, 1);
    chk_en = 0;
    #1 rst = 0;
    #1 rst_chk("midrst");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port, async-read data memory (WIDTH x DEPTH) between two requesters: port A (CPU data path) and port B (loader/debug/DMA).
- Runs a registered two-grant FSM with round-robin fairness and optional locked bursts bounded by MAX_BURST.
- Drives the memory's addr/we/wdata and returns registered read data per port.
- Sits between the requesters and the memory instance; the memory itself is unchanged.

Parameters:
- WIDTH, 16, data width.
- DEPTH, 1024, memory words.
- ADD_SIZE, $clog2(DEPTH), address width.
- MAX_BURST, 4, max consecutive grant cycles for one port while the other waits (>=1).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- a_req / b_req  in  1  access request; held high until ack.
- a_lock / b_lock  in  1  keep grant after this beat (burst).
- a_we / b_we  in  1  1=write, 0=read.
- a_addr / b_addr  in  ADD_SIZE  word address.
- a_wdata / b_wdata  in  WIDTH  write data.
- a_ack / b_ack  out  1  access performed this cycle.
- a_rdata / b_rdata  out  WIDTH  registered read data.
- a_rvalid / b_rvalid  out  1  1-cycle pulse; rdata valid.
- mem_addr  out  ADD_SIZE  to memory addr.
- mem_we  out  1  to memory we.
- mem_wdata  out  WIDTH  to memory wdata.
- mem_rdata  in  WIDTH  from memory out (async).
- owner  out  2  00 idle, 01 A, 10 B.

Behaviour:
- States: IDLE, GNT_A, GNT_B. Registers: state, rr_ptr (0=A next), burst_cnt, a/b_rdata, a/b_rvalid.
- Reset (async, immediate): state=IDLE, rr_ptr=A, burst_cnt=0, all ack/rvalid=0, rdata=0, owner=00, mem_we=0, mem_addr=0, mem_wdata=0.
- IDLE transitions:
  - only a_req -> GNT_A; only b_req -> GNT_B.
  - both -> port selected by rr_ptr.
  - none -> stay IDLE.
  - Entering GNT_x sets burst_cnt=0 and rr_ptr=other port.
- In GNT_x, mem_* muxed combinationally from port x:
  - x_ack = x_req; mem_we = x_req & x_we.
  - Write commits at the clock edge ending the ack cycle.
- Read return: on that same edge, if x_ack & !x_we, x_rdata <= mem_rdata and x_rvalid=1 for one cycle.
  - Latency: req->ack 1 cycle from IDLE; ack->rdata/rvalid 1 cycle.
- GNT_x exit: burst_cnt increments each GNT_x cycle.
  - x_lock=1 and (other req low or burst_cnt < MAX_BURST-1) -> stay GNT_x.
  - x_lock=1, other req high and burst_cnt == MAX_BURST-1 -> GNT_other (forced release).
  - x_lock=0 and other req high -> GNT_other.
  - x_lock=0, other req low -> IDLE. Unlocked same-port back-to-back costs one bubble.
- Locked with x_req low: no ack, no write. The cycle still counts toward burst_cnt.
- x_req dropped in a grant cycle: no ack, no write, rdata unchanged.
- IDLE/other-port cycles: mem_we=0, mem_addr and mem_wdata=0, both acks 0.
- Never both acks in one cycle; owner reflects state.
- Reset mid-burst: write suppressed at once (mem_we=0 combinationally); the pending read returns no rvalid.

Optional Feature:
- MEM_ARB_STATS_EN defined adds outputs a_wait_cnt and b_wait_cnt, 16 bits each.
  - Each increments every cycle its req=1 and ack=0.
  - Saturates at 0xFFFF; async reset to 0.
  - Input stats_clr (1, sync) zeroes both counters; stats_clr has priority over increment.
- Undefined: these ports and logic are absent; behaviour otherwise identical.

Test Plan:
- Reset: pulse rst low mid-traffic -> all outputs 0, owner=00, same cycle.
- A write 0x010=0xBEEF (a_req at cycle 0) -> a_ack and mem_we=1 in cycle 1. Then B read 0x010 -> b_ack, then b_rvalid=1 with b_rdata=0xBEEF one cycle later.
- a_req and b_req together from reset -> A served first, then B. A second simultaneous pair from IDLE -> B first (rr alternation).
- MAX_BURST=4, A locked 8 writes 0x100..0x107 while b_req held -> A acks 4 consecutive cycles, B acks 1 cycle, A resumes at 0x104.
- Unlocked A reads of 0x000,0x001 with B idle -> ack cycles 1 and 3 (bubble at 2); rvalid at cycles 2 and 4.
- MEM_ARB_STATS_EN: B waits 3 cycles behind a locked A -> b_wait_cnt=3. stats_clr -> 0.
